// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
// Contents: FSM state type, field widths, and derived layout of the working
// shift register {hund, tens, ones, bin}.
package bcd_pkg;

  localparam int unsigned BIN_W  = 8;  // binary input width
  localparam int unsigned ITER   = 8;  // one shift per input bit
  localparam int unsigned BCD_W  = 4;  // ones / tens nibble width
  localparam int unsigned HUND_W = 2;  // hundreds field, 0..2 only

  // Working register layout, LSB first: bin, ones, tens, hund.
  localparam int unsigned SR_W    = HUND_W + 2 * BCD_W + BIN_W;
  localparam int unsigned ONES_LO = BIN_W;
  localparam int unsigned TENS_LO = BIN_W + BCD_W;
  localparam int unsigned HUND_LO = BIN_W + 2 * BCD_W;

  localparam int unsigned CNT_W = 3;  // counts 0..ITER-1

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

endpackage

// File: rtl/bcd_nibble_adj.sv
// Double-dabble digit correction: adds 3 to a BCD nibble that is >= 5 so
// the following left shift carries correctly into the next decimal digit.
// Ports:
//   nibble   - BCD digit before correction
//   adjusted - corrected digit
module bcd_nibble_adj
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] nibble,
  output logic [BCD_W-1:0] adjusted
);

  always_comb begin
    adjusted = nibble;
    if (nibble >= BCD_W'(5)) adjusted = nibble + BCD_W'(3);
  end

endmodule

// File: rtl/bin8_to_bcd_seq.sv
// Sequential shift-and-add-3 converter: 8-bit binary to three BCD digits.
// A START seen in IDLE captures BIN; eight shift cycles later the digits
// are registered onto ONES/TENS/HUNDREDS together with a one-cycle DONE.
// Ports:
//   CLOCK_50  - system clock, rising edge
//   RESET_N   - asynchronous active-low reset
//   START     - conversion request, honoured only while idle
//   BIN       - binary value, captured on the accepting edge
//   BUSY      - conversion in progress
//   DONE      - one-cycle pulse, digits updated on the same edge
//   ONES/TENS/HUNDREDS - last completed result, held between conversions
module bin8_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned WIDTH = 8  // only 8 is supported
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic              START,
  input  logic [WIDTH-1:0]  BIN,
  output logic              BUSY,
  output logic              DONE,
  output logic [BCD_W-1:0]  ONES,
  output logic [BCD_W-1:0]  TENS,
  output logic [HUND_W-1:0] HUNDREDS
);

  state_e              state_q, state_d;
  logic [SR_W-1:0]     sr_q, sr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [BCD_W-1:0]    ones_q, ones_d;
  logic [BCD_W-1:0]    tens_q, tens_d;
  logic [HUND_W-1:0]   hund_q, hund_d;

  logic [BCD_W-1:0]    ones_adj, tens_adj;
  logic [SR_W-1:0]     sr_adj, sr_shift;

  bcd_nibble_adj u_adj_ones (
    .nibble   (sr_q[ONES_LO +: BCD_W]),
    .adjusted (ones_adj)
  );

  bcd_nibble_adj u_adj_tens (
    .nibble   (sr_q[TENS_LO +: BCD_W]),
    .adjusted (tens_adj)
  );

  // Hundreds never reaches 5 for an 8-bit input, so it is left uncorrected.
  always_comb begin
    sr_adj   = {sr_q[HUND_LO +: HUND_W], tens_adj, ones_adj, sr_q[BIN_W-1:0]};
    sr_shift = {sr_adj[SR_W-2:0], 1'b0};
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ones_d  = ones_q;
    tens_d  = tens_q;
    hund_d  = hund_q;
    unique case (state_q)
      IDLE: begin
        if (START) begin
          sr_d    = {{(SR_W - BIN_W){1'b0}}, BIN[BIN_W-1:0]};
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = sr_shift;
        cnt_d = cnt_q + 1'b1;
        // Final shift: publish the post-shift digits on this same edge.
        if (cnt_q == CNT_W'(ITER - 1)) begin
          ones_d  = sr_shift[ONES_LO +: BCD_W];
          tens_d  = sr_shift[TENS_LO +: BCD_W];
          hund_d  = sr_shift[HUND_LO +: HUND_W];
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ones_q  <= '0;
      tens_q  <= '0;
      hund_q  <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ones_q  <= ones_d;
      tens_q  <= tens_d;
      hund_q  <= hund_d;
    end
  end

  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign ONES     = ones_q;
  assign TENS     = tens_q;
  assign HUNDREDS = hund_q;

endmodule
